// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile
//   AXI4-Lite slave that fronts a bank of NUM_REGS memory-mapped registers.
//   Write path: AW and W are buffered independently, the write is committed
//   once both buffers hold data, and the response is held until BREADY.
//   Read path: single outstanding read, data captured on the AR handshake.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   AW*/W*/B*           AXI4-Lite write address / data / response channels
//   AR*/R*              AXI4-Lite read address / data channels
//   reg_q               flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse        one-cycle pulse per register, the cycle after an OKAY write
//
// Write FSM
//   state      | meaning
//   WR_COLLECT | gathering AW and W into their holding buffers
//   WR_RESP    | write committed, BVALID held until BREADY
// Read FSM
//   state      | meaning
//   RD_IDLE    | ARREADY high, waiting for a read address
//   RD_VALID   | RDATA/RRESP held with RVALID until RREADY

module axi4_lite_slave_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] WR_COLLECT = 1'b0;
  localparam logic [0:0] WR_RESP    = 1'b1;
  localparam logic [0:0] RD_IDLE    = 1'b0;
  localparam logic [0:0] RD_VALID   = 1'b1;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS > (1 << IDX_W)) begin : g_bad_regs
    $error("NUM_REGS exceeds the decodable address range");
  end

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [0:0]            wr_state;
  logic [0:0]            rd_state;
  logic                  aw_full;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  commit;

  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_hit;
  logic [DATA_WIDTH-1:0] ar_data;
  logic                  wr_hit;

  // Byte-lane address bits are not part of the register index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign b_hs   = BVALID & BREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign r_hs   = RVALID & RREADY;
  assign commit = (wr_state == WR_COLLECT) & aw_full & w_full;
  assign ar_idx = ARADDR[ADDR_LSB +: IDX_W];

  // Decoding by explicit match keeps out-of-range indices from ever
  // addressing the register array.
  always_comb begin
    ar_hit  = 1'b0;
    ar_data = '0;
    wr_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        ar_hit  = 1'b1;
        ar_data = regs[i];
      end
      if (aw_idx_q == IDX_W'(i)) begin
        wr_hit = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state     <= WR_COLLECT;
      rd_state     <= RD_IDLE;
      aw_full      <= 1'b0;
      aw_idx_q     <= '0;
      w_full       <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      AWREADY      <= 1'b0;
      WREADY       <= 1'b0;
      BVALID       <= 1'b0;
      BRESP        <= RESP_OKAY;
      ARREADY      <= 1'b0;
      RVALID       <= 1'b0;
      RRESP        <= RESP_OKAY;
      RDATA        <= '0;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      reg_wr_pulse <= '0;

      case (wr_state)
        WR_COLLECT: begin
          if (aw_hs) begin
            aw_idx_q <= AWADDR[ADDR_LSB +: IDX_W];
            aw_full  <= 1'b1;
            AWREADY  <= 1'b0;
          end else if (!aw_full) begin
            AWREADY  <= 1'b1;
          end

          if (w_hs) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
            w_full   <= 1'b1;
            WREADY   <= 1'b0;
          end else if (!w_full) begin
            WREADY   <= 1'b1;
          end

          // Both buffers full implies both READYs are already low, so the
          // handshake branches above cannot fire on a commit edge.
          if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (aw_idx_q == IDX_W'(i)) begin
                for (int k = 0; k < STRB_W; k++) begin
                  if (w_strb_q[k]) begin
                    regs[i][k*8 +: 8] <= w_data_q[k*8 +: 8];
                  end
                end
                reg_wr_pulse[i] <= 1'b1;
              end
            end
            BRESP    <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            BVALID   <= 1'b1;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            wr_state <= WR_COLLECT;
          end
        end
        default: wr_state <= WR_COLLECT;
      endcase

      case (rd_state)
        RD_IDLE: begin
          // regs[] is sampled before this edge's commit lands, so a
          // colliding read returns the pre-write value.
          if (ar_hs) begin
            RDATA    <= ar_hit ? ar_data : '0;
            RRESP    <= ar_hit ? RESP_OKAY : RESP_SLVERR;
            RVALID   <= 1'b1;
            ARREADY  <= 1'b0;
            rd_state <= RD_VALID;
          end else begin
            ARREADY  <= 1'b1;
          end
        end
        RD_VALID: begin
          if (r_hs) begin
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Self-checking bench for axi4_lite_slave_regfile (32-bit data, 6-bit
// address, 8 registers so that high addresses decode out of range).
// Expected B and R responses are queued when a transfer is issued and
// compared by a monitor when the matching handshake appears.

module tb_axi4_lite_slave_regfile;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;

  logic              ACLK;
  logic              ARESET;
  logic [AW-1:0]     AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DW-1:0]     WDATA;
  logic [DW/8-1:0]   WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [AW-1:0]     ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DW-1:0]     RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     reg_wr_pulse;

  axi4_lite_slave_regfile #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .AWADDR      (AWADDR),
    .AWVALID     (AWVALID),
    .AWREADY     (AWREADY),
    .WDATA       (WDATA),
    .WSTRB       (WSTRB),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .ARADDR      (ARADDR),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .reg_q       (reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0] bq [$];
  rexp_t      rq [$];
  int         total = 0;
  int         bad   = 0;
  int         pulse_cnt [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_val(input int i);
    return reg_q[i*DW +: DW];
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  end

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (BVALID && BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", BRESP, bq.pop_front());
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rdata", RDATA, e.d);
          chk("rresp", RRESP, e.r);
        end
      end
      for (int i = 0; i < NR; i++) pulse_cnt[i] += int'(reg_wr_pulse[i]);
    end
  end

  // Drives AW and/or W starting together; each drops after its own handshake.
  task automatic send(input bit do_aw, input bit do_w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    bit a_go, w_go;
    AWADDR  = a;
    AWVALID = do_aw;
    WDATA   = d;
    WSTRB   = s;
    WVALID  = do_w;
    for (int n = 0; n < 50; n++) begin
      if (!AWVALID && !WVALID) break;
      @(negedge ACLK);
      a_go = AWVALID && AWREADY;
      w_go = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (a_go) AWVALID = 1'b0;
      if (w_go) WVALID = 1'b0;
    end
    if (AWVALID || WVALID) begin
      chk("aw_w_timeout", 1, 0);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end
  endtask

  task automatic wait_b();
    bit got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge ACLK);
      if (BVALID && BREADY) got = 1'b1;
      @(posedge ACLK); #1;
      if (got) break;
    end
    if (!got) chk("b_timeout", 1, 0);
  endtask

  task automatic wait_r();
    bit got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge ACLK);
      if (RVALID && RREADY) got = 1'b1;
      @(posedge ACLK); #1;
      if (got) break;
    end
    if (!got) chk("r_timeout", 1, 0);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    BREADY = 1'b1;
    send(1'b1, 1'b1, a, d, s);
    wait_b();
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] r);
    rexp_t e;
    bit    got = 1'b0;
    e.d = d;
    e.r = r;
    rq.push_back(e);
    RREADY  = 1'b1;
    ARADDR  = a;
    ARVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge ACLK);
      if (ARREADY) got = 1'b1;
      @(posedge ACLK); #1;
      if (got) break;
    end
    ARVALID = 1'b0;
    if (!got) chk("ar_timeout", 1, 0);
    else wait_r();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          snap [NR];
    logic [31:0] snapv [NR];
    bit          seen;

    ARESET  = 1'b1;
    AWADDR  = '0; AWVALID = 1'b0;
    WDATA   = '0; WSTRB   = '0; WVALID = 1'b0;
    BREADY  = 1'b1;
    ARADDR  = '0; ARVALID = 1'b0;
    RREADY  = 1'b1;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready",  WREADY,  0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid",  BVALID,  0);
    chk("rst_rvalid",  RVALID,  0);
    chk("rst_rdata",   RDATA,   0);
    chk("rst_pulse",   reg_wr_pulse, 0);
    chk("rst_reg_any", |reg_q, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_wready",  WREADY,  1);
    chk("post_rst_arready", ARREADY, 1);
    @(posedge ACLK); #1;

    // 1: AW and W in the same cycle, latency and single pulse
    for (int i = 0; i < NR; i++) snap[i] = pulse_cnt[i];
    bq.push_back(2'b00);
    AWADDR = 6'h08; AWVALID = 1'b1;
    WDATA  = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    chk("t1_hs_ready", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("t1_bvalid_early", BVALID, 0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t1_bvalid", BVALID, 1);
    chk("t1_pulse", reg_wr_pulse, 8'h04);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t1_pulse_gone", reg_wr_pulse, 0);
    chk("t1_reg2", reg_val(2), 32'hDEADBEEF);
    chk("t1_pulse_cnt2", pulse_cnt[2] - snap[2], 1);
    @(posedge ACLK); #1;

    // 2: W three cycles ahead of AW, partial strobes
    axi_write(6'h04, 32'hFFFFFFFF, 4'hF, 2'b00);
    bq.push_back(2'b00);
    WDATA = 32'h11223344; WSTRB = 4'h5; WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t2_awready", AWREADY, 1);
      chk("t2_wready", WREADY, (i == 0) ? 1 : 0);
      chk("t2_bvalid", BVALID, 0);
      @(posedge ACLK); #1;
      WVALID = 1'b0;
    end
    send(1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    wait_b();
    chk("t2_reg1", reg_val(1), 32'hFF22FF44);

    // 3: out-of-range write and read
    for (int i = 0; i < NR; i++) begin
      snap[i]  = pulse_cnt[i];
      snapv[i] = reg_val(i);
    end
    axi_write(6'h3C, 32'hA5A5A5A5, 4'hF, 2'b10);
    for (int i = 0; i < NR; i++) begin
      chk("t3_reg_same", reg_val(i), snapv[i]);
      chk("t3_no_pulse", pulse_cnt[i] - snap[i], 0);
    end
    axi_read(6'h3C, 32'h0, 2'b10);

    // 4: B back-pressure, second AW held off until after BREADY
    bq.push_back(2'b00);
    BREADY = 1'b0;
    send(1'b1, 1'b1, 6'h10, 32'h12345678, 4'hF);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge ACLK);
      if (BVALID) seen = 1'b1;
      @(posedge ACLK); #1;
      if (seen) break;
    end
    chk("t4_bvalid_seen", seen, 1);
    bq.push_back(2'b00);
    AWADDR = 6'h14; AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t4_bvalid_hold", BVALID, 1);
      chk("t4_bresp_hold", BRESP, 0);
      chk("t4_awready_low", AWREADY, 0);
      chk("t4_wready_low", WREADY, 0);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    chk("t4_awready_at_bready", AWREADY, 0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t4_awready_after", AWREADY, 1);
    chk("t4_bvalid_clr", BVALID, 0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    send(1'b0, 1'b1, 6'h14, 32'hCAFEF00D, 4'hF);
    wait_b();
    chk("t4_reg4", reg_val(4), 32'h12345678);
    chk("t4_reg5", reg_val(5), 32'hCAFEF00D);

    // 5: R back-pressure, then read/write collision on reg3
    begin
      rexp_t e;
      e.d = 32'hDEADBEEF; e.r = 2'b00;
      rq.push_back(e);
    end
    RREADY = 1'b0;
    ARADDR = 6'h08; ARVALID = 1'b1;
    @(negedge ACLK);
    chk("t5_arready", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("t5_rdata_hold", RDATA, 32'hDEADBEEF);
      chk("t5_rvalid_hold", RVALID, 1);
      chk("t5_arready_low", ARREADY, 0);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b1;
    wait_r();
    begin
      rexp_t e;
      e.d = 32'h0; e.r = 2'b00;
      rq.push_back(e);
    end
    bq.push_back(2'b00);
    BREADY = 1'b1;
    AWADDR = 6'h0C; AWVALID = 1'b1;
    WDATA = 32'h5; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    chk("t5_col_awready", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 6'h0C; ARVALID = 1'b1;
    @(negedge ACLK);
    chk("t5_col_arready", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    wait_r();
    chk("t5_reg3", reg_val(3), 32'h5);
    axi_read(6'h0C, 32'h5, 2'b00);

    // 6: reset between AW and W drops the stale address
    send(1'b1, 1'b0, 6'h18, 32'h0, 4'h0);
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("t6_rst_awready", AWREADY, 0);
    chk("t6_rst_regs", |reg_q, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    for (int i = 0; i < NR; i++) snap[i] = pulse_cnt[i];
    send(1'b0, 1'b1, 6'h00, 32'h55AA55AA, 4'hF);
    repeat (3) begin
      @(negedge ACLK);
      chk("t6_no_stale_commit", BVALID, 0);
      @(posedge ACLK); #1;
    end
    bq.push_back(2'b00);
    send(1'b1, 1'b0, 6'h00, 32'h0, 4'h0);
    wait_b();
    chk("t6_reg0", reg_val(0), 32'h55AA55AA);
    chk("t6_reg6", reg_val(6), 32'h0);
    chk("t6_pulse0", pulse_cnt[0] - snap[0], 1);
    chk("t6_pulse6", pulse_cnt[6] - snap[6], 0);

    repeat (2) @(posedge ACLK);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
Parametrised AXI4-Lite slave with a full write path (AW/W/B) and read path (AR/R) into a bank of NUM_REGS memory-mapped registers.
- Adds byte strobes, read-back, SLVERR decode and per-register write pulses.
- Register contents are exported as a flat bus for downstream peripheral logic.
- Sits between the AXI4-Lite interconnect and peripheral control/status logic.

Parameters:
DATA_WIDTH, 32, bus and register width; legal values 32 or 64.
ADDR_WIDTH, 6, byte address width.
NUM_REGS, 16, number of registers; must satisfy NUM_REGS <= 2^(ADDR_WIDTH-ADDR_LSB).
(Derived: ADDR_LSB = log2(DATA_WIDTH/8); IDX_W = ADDR_WIDTH-ADDR_LSB.)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous reset, active-high
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte write strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response: 00 OKAY, 10 SLVERR
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register i is written (OKAY writes only)

Behaviour:
- Reset (ARESET=1 at an edge): all registers = 0; BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0; reg_wr_pulse = 0; AW/W holding buffers emptied.
- READY outputs are registered. They are 0 while ARESET is high and 1 on the first cycle after it is released.
- Reset mid-transaction: any in-flight AW/W/B/AR/R is dropped with no register update. Reset dominates all other events.
- Write FSM has two states, WR_COLLECT and WR_RESP.
- WR_COLLECT:
  - AW and W channels are independent; either may arrive first, or both in the same cycle.
  - AW handshake (AWVALID & AWREADY) latches AWADDR; AWREADY then drops to 0 until BREADY completes the response.
  - W handshake latches WDATA/WSTRB; WREADY then drops to 0 under the same rule.
  - On the edge after both buffers are full: commit the write and move to WR_RESP with BVALID=1.
  - Latency: AW and W in the same cycle at edge N gives BVALID high after edge N+1.
- Address decode: idx = addr[ADDR_LSB +: IDX_W]; addr[ADDR_LSB-1:0] is ignored.
- Commit rules:
  - If idx < NUM_REGS: byte k of register idx is updated only when WSTRB[k]=1; BRESP=00; reg_wr_pulse[idx]=1 for exactly one cycle.
  - If idx >= NUM_REGS: no update, no pulse, BRESP=10.
  - WSTRB=0 with a valid idx: no data change, BRESP=00, pulse still asserted.
- WR_RESP: BVALID and BRESP are held stable until BREADY. On the BVALID & BREADY edge: BVALID=0, state returns to WR_COLLECT, AWREADY=WREADY=1.
- Read FSM has two states, RD_IDLE and RD_VALID.
- RD_IDLE: ARREADY=1. On AR handshake, on that same edge:
  - RDATA = register[idx] and RRESP = 00, or RDATA = 0 and RRESP = 10 if idx >= NUM_REGS.
  - RVALID=1 and ARREADY=0; state moves to RD_VALID.
- RD_VALID: RDATA, RRESP and RVALID are held until RREADY. On the RVALID & RREADY edge: RVALID=0 and ARREADY=1. There is no back-to-back acceptance in the same cycle.
- Read/write collision: if the AR handshake falls on the same edge as a write commit to the same register, RDATA returns the pre-write value.
- Read and write paths operate concurrently with no arbitration stall.

Test Plan:
1. Reset then AW=0x08 and W=0xDEADBEEF, WSTRB=0xF in the same cycle; BREADY=1 -> BVALID high 2 cycles after the handshake, BRESP=00, reg2=0xDEADBEEF, reg_wr_pulse[2] pulses once.
2. W (0x11223344, WSTRB=0x5) presented 3 cycles before AW=0x04, with reg1 previously 0xFFFFFFFF -> AWREADY stays 1 until the AW handshake, reg1=0xFF22FF44, BRESP=00.
3. AW=0x3C with NUM_REGS=8 (idx 15) -> BRESP=10, no register changes, reg_wr_pulse all 0. AR=0x3C -> RDATA=0, RRESP=10.
4. BREADY held 0 for 5 cycles -> BVALID/BRESP stable throughout, AWREADY=WREADY=0 throughout, and a second AWVALID is not accepted until the cycle after BREADY.
5. Read reg2 with RREADY held low for 4 cycles -> RDATA=0xDEADBEEF stable, ARREADY=0 throughout. Then a same-edge AR to reg3 plus a write commit of 0x5 to reg3 -> RDATA returns the old reg3 value (0).
6. ARESET asserted after the AW handshake but before W -> all buffers cleared. A subsequent lone W followed by AW=0x00 writes reg0 only; no write to the stale address occurs.
